// File: rtl/pam_frame_sched.sv
// ============================================================================
// Module   : pam_frame_sched
// Brief    : PAM sender frame scheduler: header ROM, payload symbols, gap fill.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pam_frame_sched #(
    parameter int AD_CVER_WIDTH  = 12,
    parameter int ADDR_MEM_WIDTH = 5,
    parameter int PAM_ORDER      = 4,
    parameter int HEAD_LEN       = 32,
    parameter int PAYLOAD_LEN    = 256,
    parameter int GAP_LEN        = 8,
    parameter int CNT_WIDTH      = 16,
    localparam int SYM_W         = $clog2(PAM_ORDER)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_en,
    input  logic [SYM_W-1:0]          in_sym,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ADDR_MEM_WIDTH-1:0] head_addr,
    output logic                      head_rd,
    input  logic [AD_CVER_WIDTH-1:0]  head_data,
    output logic [AD_CVER_WIDTH-1:0]  sent_data,
    output logic                      sent_valid,
    output logic                      sent_sof,
    output logic                      sent_eof,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      frame_cnt,
    output logic [CNT_WIDTH-1:0]      underrun_cnt
);

    localparam int c_MAXLEN = (HEAD_LEN > PAYLOAD_LEN) ?
                              ((HEAD_LEN > GAP_LEN) ? HEAD_LEN : GAP_LEN) :
                              ((PAYLOAD_LEN > GAP_LEN) ? PAYLOAD_LEN : GAP_LEN);
    localparam int c_POS_W  = (c_MAXLEN > 1) ? $clog2(c_MAXLEN) : 1;

    localparam logic [c_POS_W-1:0] c_HEAD_LAST = c_POS_W'(HEAD_LEN - 1);
    localparam logic [c_POS_W-1:0] c_PAY_LAST  = c_POS_W'(PAYLOAD_LEN - 1);
    localparam logic [c_POS_W-1:0] c_GAP_LAST  = c_POS_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    localparam logic [AD_CVER_WIDTH-1:0] c_MID  = {1'b1, {(AD_CVER_WIDTH-1){1'b0}}};
    localparam logic [AD_CVER_WIDTH-1:0] c_STEP =
        AD_CVER_WIDTH'(((2 ** AD_CVER_WIDTH) - 1) / (PAM_ORDER - 1));

    localparam logic [1:0] c_TAG_MID  = 2'd0;
    localparam logic [1:0] c_TAG_HEAD = 2'd1;
    localparam logic [1:0] c_TAG_SYM  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEAD    = 2'd1,
        S_PAYLOAD = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nx;
    logic [c_POS_W-1:0]          r_pos;
    logic [c_POS_W-1:0]          w_pos_nx;
    logic                        w_frame_done;
    logic                        w_start;

    logic                        r_in_ready;
    logic                        r_head_rd;
    logic [ADDR_MEM_WIDTH-1:0]   r_head_addr;
    logic [CNT_WIDTH-1:0]        r_frame_cnt;
    logic [CNT_WIDTH-1:0]        r_underrun_cnt;

    logic [1:0]                  r_s1_tag;
    logic [SYM_W-1:0]            r_s1_sym;
    logic                        r_s1_valid;
    logic                        r_s1_sof;
    logic                        r_s1_eof;
    logic [AD_CVER_WIDTH-1:0]    w_level;

    logic [AD_CVER_WIDTH-1:0]    r_sent_data;
    logic                        r_sent_valid;
    logic                        r_sent_sof;
    logic                        r_sent_eof;

    assign w_start = cfg_en && in_valid;

    always_comb begin
        w_state_nx   = r_state;
        w_pos_nx     = r_pos;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nx = S_HEAD;
                    w_pos_nx   = '0;
                end
            end
            S_HEAD: begin
                if (r_pos == c_HEAD_LAST) begin
                    w_state_nx = S_PAYLOAD;
                    w_pos_nx   = '0;
                end else begin
                    w_pos_nx   = r_pos + 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (r_pos == c_PAY_LAST) begin
                    w_pos_nx = '0;
                    if (GAP_LEN > 0) begin
                        w_state_nx = S_GAP;
                    end else begin
                        // Without a gap the frame closes on its last payload slot
                        w_frame_done = 1'b1;
                        w_state_nx   = w_start ? S_HEAD : S_IDLE;
                    end
                end else begin
                    w_pos_nx = r_pos + 1'b1;
                end
            end
            S_GAP: begin
                if (r_pos == c_GAP_LAST) begin
                    w_frame_done = 1'b1;
                    w_state_nx   = w_start ? S_HEAD : S_IDLE;
                    w_pos_nx     = '0;
                end else begin
                    w_pos_nx     = r_pos + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_pos_nx   = '0;
            end
        endcase
    end

    // Control outputs are registered from the next state so they line up with the slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_pos          <= '0;
            r_in_ready     <= 1'b0;
            r_head_rd      <= 1'b0;
            r_head_addr    <= '0;
            r_frame_cnt    <= '0;
            r_underrun_cnt <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_pos       <= w_pos_nx;
            r_in_ready  <= (w_state_nx == S_PAYLOAD);
            r_head_rd   <= (w_state_nx == S_HEAD);
            r_head_addr <= (w_state_nx == S_HEAD) ? ADDR_MEM_WIDTH'(w_pos_nx) : '0;
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if ((r_state == S_PAYLOAD) && !in_valid && (r_underrun_cnt != {CNT_WIDTH{1'b1}})) begin
                r_underrun_cnt <= r_underrun_cnt + 1'b1;
            end
        end
    end

    // Stage 1: tag the slot source while the ROM access is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_tag   <= c_TAG_MID;
            r_s1_sym   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eof   <= 1'b0;
        end else begin
            r_s1_tag   <= c_TAG_MID;
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eof   <= 1'b0;
            case (r_state)
                S_HEAD: begin
                    r_s1_tag   <= c_TAG_HEAD;
                    r_s1_valid <= 1'b1;
                    r_s1_sof   <= (r_pos == '0);
                end
                S_PAYLOAD: begin
                    r_s1_valid <= 1'b1;
                    r_s1_eof   <= (r_pos == c_PAY_LAST);
                    if (in_valid) begin
                        r_s1_tag <= c_TAG_SYM;
                        r_s1_sym <= in_sym;
                    end
                end
                default: begin
                    r_s1_tag <= c_TAG_MID;
                end
            endcase
        end
    end

    assign w_level = AD_CVER_WIDTH'(r_s1_sym) * c_STEP;

    // Stage 2: output mux
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sent_data  <= c_MID;
            r_sent_valid <= 1'b0;
            r_sent_sof   <= 1'b0;
            r_sent_eof   <= 1'b0;
        end else begin
            case (r_s1_tag)
                c_TAG_HEAD: r_sent_data <= head_data;
                c_TAG_SYM:  r_sent_data <= w_level;
                default:    r_sent_data <= c_MID;
            endcase
            r_sent_valid <= r_s1_valid;
            r_sent_sof   <= r_s1_sof;
            r_sent_eof   <= r_s1_eof;
        end
    end

    assign in_ready     = r_in_ready;
    assign head_rd      = r_head_rd;
    assign head_addr    = r_head_addr;
    assign sent_data    = r_sent_data;
    assign sent_valid   = r_sent_valid;
    assign sent_sof     = r_sent_sof;
    assign sent_eof     = r_sent_eof;
    assign busy         = (r_state != S_IDLE);
    assign frame_cnt    = r_frame_cnt;
    assign underrun_cnt = r_underrun_cnt;

endmodule

`default_nettype wire

// File: doc/pam_frame_sched.md
Name: pam_frame_sched

Overview:
Frame scheduler for the PAM sender. It builds transmit frames for the constant-rate DAC by sequencing three sources: header samples read from the head-frame ROM, PAM-mapped payload symbols from upstream, and mid-level idle/gap filler. It owns the header ROM read port and the upstream ready signal, and emits one DAC sample per clock.

Parameters:
AD_CVER_WIDTH, 12, DAC sample width.
ADDR_MEM_WIDTH, 5, header ROM address width.
PAM_ORDER, 4, PAM levels (power of 2, >=2). SYM_W = log2(PAM_ORDER).
HEAD_LEN, 32, header samples per frame. Range 1..2^ADDR_MEM_WIDTH.
PAYLOAD_LEN, 256, payload symbols per frame. Must be >=1.
GAP_LEN, 8, idle samples after each frame. 0 is allowed and skips GAP.
CNT_WIDTH, 16, width of the frame and underrun counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_en  in  1  level signal; enables frame generation
in_sym  in  SYM_W  upstream PAM symbol
in_valid  in  1  upstream valid
in_ready  out  1  scheduler accepts in_sym
head_addr  out  ADDR_MEM_WIDTH  header ROM address
head_rd  out  1  header ROM read enable
head_data  in  AD_CVER_WIDTH  ROM data, valid 1 cycle after head_rd
sent_data  out  AD_CVER_WIDTH  DAC sample
sent_valid  out  1  sent_data is a header or payload sample
sent_sof  out  1  first header sample of a frame
sent_eof  out  1  last payload sample of a frame
busy  out  1  state is not IDLE
frame_cnt  out  CNT_WIDTH  frames completed; wraps
underrun_cnt  out  CNT_WIDTH  payload slots filled with MID; saturates

Behaviour:
- Constants: MID = 2^(AD_CVER_WIDTH-1). STEP = (2^AD_CVER_WIDTH-1)/(PAM_ORDER-1), integer division. Payload level = in_sym*STEP, computed in AD_CVER_WIDTH bits. Defaults give levels 0, 1365, 2730, 4095.
- Reset values: state IDLE; all counters 0; in_ready=0; head_rd=0; head_addr=0; sent_data=MID; sent_valid=0; sent_sof=0; sent_eof=0; busy=0. Reset mid-frame aborts the frame immediately; the aborted frame is not counted.
- FSM states: IDLE, HEAD, PAYLOAD, GAP. One position counter is loaded on each state entry.
  - IDLE -> HEAD when cfg_en=1 and in_valid=1 in the same cycle. No symbol is consumed on this transition.
  - HEAD: head_rd=1 and head_addr = index, 0..HEAD_LEN-1, one per cycle. After index HEAD_LEN-1 -> PAYLOAD.
  - PAYLOAD: exactly PAYLOAD_LEN slots, one per cycle. in_ready=1 throughout. If in_valid=1, the symbol is consumed and mapped. If in_valid=0, the slot carries MID, sent_valid is still 1, and underrun_cnt increments. After the last slot -> GAP, or -> IDLE/HEAD when GAP_LEN=0.
  - GAP: GAP_LEN cycles of MID with sent_valid=0. At the end, frame_cnt increments and the next state is HEAD if cfg_en=1 and in_valid=1, else IDLE.
  - When GAP_LEN=0, frame_cnt increments on the last payload slot.
- cfg_en deasserted mid-frame: the current frame and its GAP complete normally, then the FSM goes to IDLE. Frames are never truncated.
- Latency: 2 cycles from FSM slot to sent_*, uniform for all sources.
  - Stage 1: ROM access, or symbol capture plus source tag.
  - Stage 2: registered mux selects head_data, the mapped level, or MID.
  - A header slot with address at cycle t appears on sent_data at t+2. A payload accept at cycle t appears at t+2.
- Back-to-back frames: the first HEAD slot of frame N+1 follows the last GAP slot of frame N with no idle cycle.
- sent_sof and sent_eof are 1-cycle pulses aligned with the corresponding sent_data. When HEAD_LEN=PAYLOAD_LEN=1, both pulses still appear on their respective samples.
- in_ready is 0 outside PAYLOAD. Upstream holds in_sym until it is accepted.
- busy = (state != IDLE).

Test Plan:
1. Test configuration: HEAD_LEN=4, PAYLOAD_LEN=8, GAP_LEN=2. The ROM holds 100+addr. cfg_en=1, in_valid=1, in_sym incrementing mod 4. Required: sent_data = 100,101,102,103 (sof on 100), then 0,1365,2730,4095,0,1365,2730,4095 (eof on the last), then 2048,2048 with sent_valid=0. frame_cnt=1.
2. Same setup, continuous input for 3 frames -> frame period of exactly 14 cycles, frame_cnt=3, no idle cycles between frames.
3. in_valid dropped for payload slots 2 and 5 -> those slots output 2048 with sent_valid=1, underrun_cnt=2, and the frame length is unchanged.
4. cfg_en dropped during HEAD of frame 2 -> frame 2 completes including GAP, then busy=0, in_ready=0, frame_cnt=2.
5. rst asserted during PAYLOAD slot 3 -> the next cycle shows state IDLE, sent_data=2048, sent_valid=0, and all counters 0. With cfg_en=1 and in_valid=1 after rst drops, the new frame starts with sent_sof on ROM address 0.
6. GAP_LEN=0 and cfg_en=0 initially. Assert cfg_en with in_valid=0, then raise in_valid after 5 cycles -> HEAD starts in the cycle after in_valid rises. Frames then run back-to-back with a 12-cycle period.
